spl_instrn_sched: RTL and testbench
===================================

# spl_instrn_sched

Memory-clock scheduler that shares the main controller engine between AXI memory transfers and CSR special instructions (command transfer, read transfer). It consumes the single-cycle `csr_cmd_xfer_valid_final` / `csr_rd_xfer_valid_final` pulses produced by the CSR instruction handler and queues them as pending requests. It grants the engine to one requester at a time with AXI/CSR alternation fairness, and returns the success pulses that release the APB-side stall.

## Interface
- `TIMEOUT_W`, 16: width of the CSR transfer watchdog counter.
- `TIMEOUT_VAL`, 16'hFFFF: watchdog reload value, in mem_clk cycles.

Ports:
- `mem_clk` in 1: sole clock.
- `mem_rst` in 1: reset, asynchronous, active-high.
- `csr_cmd_req` in 1: CSR command transfer request; single-cycle pulse.
- `csr_rd_req` in 1: CSR read transfer request; single-cycle pulse.
- `axi_xfer_req` in 1: AXI transfer request; level, held until granted.
- `axi_xfer_done` in 1: AXI transfer complete; pulse.
- `axi_xfer_gnt` out 1: engine owned by AXI; level.
- `eng_start` out 1: start CSR operation on the engine; one-cycle pulse.
- `eng_sel` out 2: engine operation select. 00 = AXI, 01 = CSR command, 10 = CSR read.
- `eng_done` in 1: engine finished the CSR operation; pulse.
- `csr_cmd_xfer_success` out 1: CSR command completed; pulse.
- `csr_rd_xfer_success` out 1: CSR read completed; pulse.
- `csr_xfer_timeout` out 1: CSR operation abandoned by the watchdog; pulse.
- `sched_busy` out 1: state is not IDLE, or any CSR request is pending.

## Operation
- Pending flags `cmd_pend` and `rd_pend`:
  - Set on the edge after the corresponding request pulse.
  - Cleared on entry to CSR_START for that type.
  - A request arriving while its own flag is already set is merged, not counted.
- Register `act_type` (cmd/rd) records the CSR operation in flight. Flag `last_csr` records that the previous grant went to CSR.
- FSM states: IDLE, AXI_XFER, CSR_START, CSR_WAIT.
- IDLE selects the next owner:
  - AXI is chosen if `axi_xfer_req` is high and either `last_csr` is 1 or no CSR flag is pending.
  - Otherwise `cmd_pend` wins, then `rd_pend`.
  - Choosing CSR goes to CSR_START; choosing AXI goes to AXI_XFER.
- AXI_XFER:
  - `axi_xfer_gnt` = 1, `eng_sel` = 00, `last_csr` cleared.
  - `axi_xfer_done` returns to IDLE.
  - CSR requests never preempt an AXI transfer.
- CSR_START:
  - `eng_start` = 1 and `eng_sel` = `act_type` for exactly one cycle; `last_csr` set.
  - Unconditionally moves to CSR_WAIT.
- CSR_WAIT:
  - `eng_sel` is held.
  - `eng_done` returns to IDLE and fires the success pulse for `act_type`.
- `eng_done` is ignored outside CSR_WAIT. `axi_xfer_done` is ignored outside AXI_XFER.
- Simultaneous `csr_cmd_req` and `csr_rd_req`: both flags set; the command is serviced first, the read next.
- Reset values: all outputs 0, `eng_sel` = 00, state IDLE, pending flags 0, `last_csr` 0.
- Reset asserted mid-operation clears everything; no success or timeout pulse is emitted for the aborted operation.

## Timing
- Request to start:
  - `csr_*_req` in cycle N, engine idle, no AXI request: `eng_start` asserted in cycle N+2.
  - Cycle N+1: flag set. Cycle N+2: state CSR_START.
- `eng_start`, `axi_xfer_gnt` and `eng_sel` are decoded from registered state and are glitch-free.
- `eng_done` in cycle M: success pulse in cycle M+1, registered. State is IDLE in cycle M+1. The next grant decision is made in M+1, taking effect in M+2.
- `axi_xfer_done` in cycle M: `axi_xfer_gnt` low in cycle M+1.
- Success pulses are exactly one cycle wide and mutually exclusive.

## Configuration
- `SPL_INSTRN_TIMEOUT_EN` defined:
  - Watchdog loads `TIMEOUT_VAL` in CSR_START and decrements each CSR_WAIT cycle.
  - On reaching 0 without `eng_done`: `csr_xfer_timeout` pulses in the next cycle, no success pulse fires, state returns to IDLE.
  - `eng_done` in the same cycle the count reaches 0 wins: success is reported, timeout is not.
- Undefined: the watchdog counter is not built, `csr_xfer_timeout` is tied to 0, and CSR_WAIT waits indefinitely for `eng_done`.

## Test plan
- CSR command, idle engine: `csr_cmd_req` at cycle 10 → `eng_start` at cycle 12 with `eng_sel` = 01. `eng_done` at cycle 20 → `csr_cmd_xfer_success` at cycle 21 only.
- Simultaneous `csr_cmd_req` and `csr_rd_req` at cycle 5 → command started at cycle 7. After its `eng_done`, the read is started with `eng_sel` = 10 two cycles later; two distinct success pulses.
- AXI transfer in progress plus `csr_rd_req` → no `eng_start` until `axi_xfer_done`. The read starts 2 cycles after `axi_xfer_done`.
- Fairness: `axi_xfer_req` held high, CSR command requests every 30 cycles → grants strictly alternate CSR/AXI; neither side is starved.
- `SPL_INSTRN_TIMEOUT_EN` with `TIMEOUT_VAL` = 8, `eng_done` never sent → `csr_xfer_timeout` pulses 9 cycles after `eng_start`, no success pulse, `sched_busy` low afterwards.
- `mem_rst` pulsed during CSR_WAIT → all outputs 0 immediately, and no late success pulse when `eng_done` arrives after reset release.

Source files
------------

// File: rtl/spl_instrn_sched.sv
// ============================================================================
// Module   : spl_instrn_sched
// Brief    : Shares the controller engine between AXI transfers and queued CSR
//            special instructions, with AXI/CSR alternation fairness.
//            Optional watchdog: define SPL_INSTRN_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spl_instrn_sched #(
  parameter int                   TIMEOUT_W   = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_VAL = 16'hFFFF
) (
  input  logic       mem_clk,
  input  logic       mem_rst,
  input  logic       csr_cmd_req,
  input  logic       csr_rd_req,
  input  logic       axi_xfer_req,
  input  logic       axi_xfer_done,
  output logic       axi_xfer_gnt,
  output logic       eng_start,
  output logic [1:0] eng_sel,
  input  logic       eng_done,
  output logic       csr_cmd_xfer_success,
  output logic       csr_rd_xfer_success,
  output logic       csr_xfer_timeout,
  output logic       sched_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AXI   = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  localparam logic [1:0] c_SEL_AXI = 2'b00;
  localparam logic [1:0] c_SEL_CMD = 2'b01;
  localparam logic [1:0] c_SEL_RD  = 2'b10;

  state_t     r_state;
  logic       r_cmd_pend;
  logic       r_rd_pend;
  logic       r_act_rd;
  logic       r_last_csr;
  logic       r_gnt;
  logic       r_start;
  logic [1:0] r_sel;
  logic       r_cmd_succ;
  logic       r_rd_succ;
  logic       r_timeout;

  logic w_idle;
  logic w_pick_axi;
  logic w_pick_cmd;
  logic w_pick_rd;
  logic w_expire;

  // AXI yields to pending CSR work only when the previous grant was AXI.
  assign w_idle     = (r_state == S_IDLE);
  assign w_pick_axi = w_idle && axi_xfer_req && (r_last_csr || !(r_cmd_pend || r_rd_pend));
  assign w_pick_cmd = w_idle && !w_pick_axi && r_cmd_pend;
  assign w_pick_rd  = w_idle && !w_pick_axi && !r_cmd_pend && r_rd_pend;

`ifdef SPL_INSTRN_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] c_WDOG_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [TIMEOUT_W-1:0] r_wdog;

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      r_wdog <= '0;
    end else if (r_state == S_START) begin
      r_wdog <= TIMEOUT_VAL;
    end else if ((r_state == S_WAIT) && (r_wdog != '0)) begin
      r_wdog <= r_wdog - c_WDOG_ONE;
    end
  end

  // Expires on the wait cycle whose decrement brings the count to zero.
  assign w_expire = (r_state == S_WAIT) && (r_wdog <= c_WDOG_ONE);
`else
  // No watchdog: parameters only feed a constant-false term.
  assign w_expire = 1'b0 && (TIMEOUT_VAL != '0) && (TIMEOUT_W > 0);
`endif

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      r_state    <= S_IDLE;
      r_cmd_pend <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_act_rd   <= 1'b0;
      r_last_csr <= 1'b0;
      r_gnt      <= 1'b0;
      r_start    <= 1'b0;
      r_sel      <= c_SEL_AXI;
      r_cmd_succ <= 1'b0;
      r_rd_succ  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      r_cmd_succ <= 1'b0;
      r_rd_succ  <= 1'b0;
      r_timeout  <= 1'b0;
      // A new request always lands, even on the cycle its flag is consumed.
      r_cmd_pend <= csr_cmd_req | (r_cmd_pend & ~w_pick_cmd);
      r_rd_pend  <= csr_rd_req  | (r_rd_pend  & ~w_pick_rd);
      case (r_state)
        S_IDLE: begin
          if (w_pick_axi) begin
            r_state    <= S_AXI;
            r_gnt      <= 1'b1;
            r_sel      <= c_SEL_AXI;
            r_last_csr <= 1'b0;
          end else if (w_pick_cmd || w_pick_rd) begin
            r_state    <= S_START;
            r_act_rd   <= w_pick_rd;
            r_start    <= 1'b1;
            r_sel      <= w_pick_rd ? c_SEL_RD : c_SEL_CMD;
            r_last_csr <= 1'b1;
          end
        end
        S_AXI: begin
          if (axi_xfer_done) begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            r_state    <= S_IDLE;
            r_sel      <= c_SEL_AXI;
            r_cmd_succ <= ~r_act_rd;
            r_rd_succ  <= r_act_rd;
          end else if (w_expire) begin
            r_state   <= S_IDLE;
            r_sel     <= c_SEL_AXI;
            r_timeout <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign axi_xfer_gnt         = r_gnt;
  assign eng_start            = r_start;
  assign eng_sel              = r_sel;
  assign csr_cmd_xfer_success = r_cmd_succ;
  assign csr_rd_xfer_success  = r_rd_succ;
  assign csr_xfer_timeout     = r_timeout;
  assign sched_busy           = (r_state != S_IDLE) || r_cmd_pend || r_rd_pend;

endmodule

`default_nettype wire

// File: tb/tb_spl_instrn_sched.sv
// ============================================================================
// Module   : tb_spl_instrn_sched
// Brief    : Bench for spl_instrn_sched: ownership-level reference model,
//            directed timing cases and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spl_instrn_sched;

  localparam int TV     = 8;
  localparam int M_NONE = 0;
  localparam int M_AXI  = 1;
  localparam int M_CSR  = 2;
`ifdef SPL_INSTRN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       mem_clk = 1'b0;
  logic       mem_rst = 1'b1;
  logic       csr_cmd_req = 1'b0;
  logic       csr_rd_req = 1'b0;
  logic       axi_xfer_req = 1'b0;
  logic       axi_xfer_done = 1'b0;
  logic       eng_done = 1'b0;
  logic       axi_xfer_gnt;
  logic       eng_start;
  logic [1:0] eng_sel;
  logic       csr_cmd_xfer_success;
  logic       csr_rd_xfer_success;
  logic       csr_xfer_timeout;
  logic       sched_busy;

  spl_instrn_sched #(.TIMEOUT_W(16), .TIMEOUT_VAL(16'd8)) dut (
    .mem_clk(mem_clk), .mem_rst(mem_rst),
    .csr_cmd_req(csr_cmd_req), .csr_rd_req(csr_rd_req),
    .axi_xfer_req(axi_xfer_req), .axi_xfer_done(axi_xfer_done),
    .axi_xfer_gnt(axi_xfer_gnt), .eng_start(eng_start), .eng_sel(eng_sel),
    .eng_done(eng_done),
    .csr_cmd_xfer_success(csr_cmd_xfer_success),
    .csr_rd_xfer_success(csr_rd_xfer_success),
    .csr_xfer_timeout(csr_xfer_timeout), .sched_busy(sched_busy)
  );

  always #5 mem_clk = ~mem_clk;

  // Reference model: who owns the engine, and for how long the CSR op has run.
  int cyc = 0;
  int m_own = M_NONE;
  int m_age = 0;
  bit m_rd = 1'b0;
  bit m_pc = 1'b0, m_pr = 1'b0, m_prev_csr = 1'b0;
  bit m_sc = 1'b0, m_sr = 1'b0, m_to = 1'b0;

  always @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      cyc = 0; m_own = M_NONE; m_age = 0; m_rd = 0;
      m_pc = 0; m_pr = 0; m_prev_csr = 0; m_sc = 0; m_sr = 0; m_to = 0;
    end else begin
      bit take_c, take_r;
      take_c = 0; take_r = 0;
      cyc++;
      m_sc = 0; m_sr = 0; m_to = 0;
      if (m_own == M_NONE) begin
        if (axi_xfer_req && (m_prev_csr || !(m_pc || m_pr))) begin
          m_own = M_AXI; m_prev_csr = 0;
        end else if (m_pc || m_pr) begin
          m_own = M_CSR; m_rd = !m_pc; m_age = 0; m_prev_csr = 1;
          take_c = m_pc; take_r = !m_pc;
        end
      end else if (m_own == M_AXI) begin
        if (axi_xfer_done) m_own = M_NONE;
      end else begin
        if (m_age > 0 && eng_done) begin
          m_sc = !m_rd; m_sr = m_rd; m_own = M_NONE;
        end else if (TO_EN && m_age == TV) begin
          m_to = 1; m_own = M_NONE;
        end else begin
          m_age++;
        end
      end
      m_pc = csr_cmd_req | (m_pc & !take_c);
      m_pr = csr_rd_req  | (m_pr & !take_r);
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Event log of the DUT outputs, cleared whenever reset is held.
  int  starts[$];
  int  sels[$];
  int  gseq[$];
  int  n_cmd, n_rd, n_to, cmd_cyc, rd_cyc, to_cyc, gnt_rise, gnt_fall;
  bit  prev_gnt;

  task automatic tick();
    logic [1:0] e_sel;
    @(negedge mem_clk);
    if (mem_rst) begin
      starts.delete(); sels.delete(); gseq.delete();
      n_cmd = 0; n_rd = 0; n_to = 0; cmd_cyc = -1; rd_cyc = -1; to_cyc = -1;
      gnt_rise = -1; gnt_fall = -1; prev_gnt = 0;
    end else begin
      e_sel = (m_own == M_CSR) ? (m_rd ? 2'b10 : 2'b01) : 2'b00;
      chk("gnt",     axi_xfer_gnt, m_own == M_AXI);
      chk("start",   eng_start, (m_own == M_CSR) && (m_age == 0));
      chk("sel",     eng_sel, e_sel);
      chk("cmd_ok",  csr_cmd_xfer_success, m_sc);
      chk("rd_ok",   csr_rd_xfer_success, m_sr);
      chk("timeout", csr_xfer_timeout, m_to);
      chk("busy",    sched_busy, (m_own != M_NONE) || m_pc || m_pr);
      if (eng_start) begin starts.push_back(cyc); sels.push_back(eng_sel); gseq.push_back(1); end
      if (axi_xfer_gnt && !prev_gnt) begin gseq.push_back(0); gnt_rise = cyc; end
      if (!axi_xfer_gnt && prev_gnt) gnt_fall = cyc;
      prev_gnt = axi_xfer_gnt;
      if (csr_cmd_xfer_success) begin n_cmd++; cmd_cyc = cyc; end
      if (csr_rd_xfer_success) begin n_rd++; rd_cyc = cyc; end
      if (csr_xfer_timeout) begin n_to++; to_cyc = cyc; end
    end
    csr_cmd_req = 0; csr_rd_req = 0; axi_xfer_done = 0; eng_done = 0;
  endtask

  task automatic go(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    tick();
    mem_rst = 1; axi_xfer_req = 0;
    tick(); tick();
    mem_rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int ax_cnt, nreq, cc;

    // Reset state
    do_reset();
    chk("rst_gnt", axi_xfer_gnt, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_sel", eng_sel, 0);
    chk("rst_busy", sched_busy, 0);

    // Single command on an idle engine
    go(10); csr_cmd_req = 1;
    go(20); eng_done = 1;
    go(25);
    chk("t1_nstart", starts.size(), 1);
    if (starts.size() > 0) begin chk("t1_start_cyc", starts[0], 12); chk("t1_sel", sels[0], 1); end
    chk("t1_succ_cyc", cmd_cyc, 21);
    chk("t1_ncmd", n_cmd, 1);
    chk("t1_nrd", n_rd, 0);

    // Simultaneous command and read
    do_reset();
    go(5); csr_cmd_req = 1; csr_rd_req = 1;
    go(12); eng_done = 1;
    go(20); eng_done = 1;
    go(25);
    chk("t2_nstart", starts.size(), 2);
    if (starts.size() > 1) begin
      chk("t2_cmd_cyc", starts[0], 7);  chk("t2_cmd_sel", sels[0], 1);
      chk("t2_rd_cyc", starts[1], 14);  chk("t2_rd_sel", sels[1], 2);
    end
    chk("t2_cmd_ok", cmd_cyc, 13);
    chk("t2_rd_ok", rd_cyc, 21);

    // Read behind an AXI transfer
    do_reset();
    go(2); axi_xfer_req = 1;
    go(5); axi_xfer_req = 0;
    go(6); csr_rd_req = 1;
    go(15); axi_xfer_done = 1;
    go(20); eng_done = 1;
    go(25);
    chk("t3_gnt_rise", gnt_rise, 3);
    chk("t3_gnt_fall", gnt_fall, 16);
    chk("t3_nstart", starts.size(), 1);
    if (starts.size() > 0) begin chk("t3_start_cyc", starts[0], 17); chk("t3_sel", sels[0], 2); end
    chk("t3_rd_ok", rd_cyc, 21);

    // Fairness: AXI always requesting, a command every 30 cycles
    do_reset();
    ax_cnt = 0; nreq = 0;
    while (cyc < 240) begin
      tick();
      axi_xfer_req = 1;
      if (cyc % 30 == 0 && cyc > 0 && cyc <= 180) begin csr_cmd_req = 1; nreq++; end
      ax_cnt = (m_own == M_AXI) ? ax_cnt + 1 : 0;
      if (ax_cnt >= 10) axi_xfer_done = 1;
      if (m_own == M_CSR && m_age >= 3) eng_done = 1;
    end
    cc = 0;
    for (int i = 1; i < gseq.size(); i++)
      if (gseq[i] == 1 && gseq[i-1] == 1) cc++;
    chk("fair_csr_back_to_back", cc, 0);
    chk("fair_ncmd", n_cmd, nreq);
    chk("fair_axi_served", gseq.size() - n_cmd >= 6, 1);

`ifdef SPL_INSTRN_TIMEOUT_EN
    // Watchdog with no engine response
    do_reset();
    go(3); csr_cmd_req = 1;
    go(20);
    chk("to_cyc", to_cyc, 14);
    chk("to_ncmd", n_cmd, 0);
    chk("to_busy", sched_busy, 0);
`endif

    // Reset in the middle of a CSR wait
    do_reset();
    go(3); csr_cmd_req = 1;
    go(8);
    #2 mem_rst = 1;
    #1;
    chk("mr_gnt", axi_xfer_gnt, 0);
    chk("mr_start", eng_start, 0);
    chk("mr_sel", eng_sel, 0);
    chk("mr_cmd_ok", csr_cmd_xfer_success, 0);
    chk("mr_timeout", csr_xfer_timeout, 0);
    chk("mr_busy", sched_busy, 0);
    tick(); tick();
    mem_rst = 0;
    go(2); eng_done = 1;
    go(12);
    chk("mr_late_ok", n_cmd, 0);
    chk("mr_nstart", starts.size(), 0);

    // Randomized traffic
    do_reset();
    repeat (3000) begin
      tick();
      if (!axi_xfer_req && $urandom_range(0, 7) == 0) axi_xfer_req = 1;
      else if (axi_xfer_req && m_own == M_AXI) axi_xfer_req = 0;
      csr_cmd_req   = ($urandom_range(0, 11) == 0);
      csr_rd_req    = ($urandom_range(0, 11) == 0);
      axi_xfer_done = ($urandom_range(0, 3) == 0);
      eng_done      = ($urandom_range(0, 3) == 0);
    end
    if (!TO_EN) chk("rand_no_timeout", n_to, 0);
    chk("rand_activity", (n_cmd > 10) && (n_rd > 10), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
